// File: rtl/uart_reg_bridge.sv
// Serial command bridge: pops W/R frames from the UART RX FIFO, drives a
// single-cycle register bus and pushes a one-byte response into the TX FIFO.
module uart_reg_bridge #(
  parameter int unsigned DATA_LENGTH    = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rx_empty,
  input  logic [DATA_LENGTH-1:0] receive_data,
  output logic                   rd_uart,
  input  logic                   tx_full,
  output logic                   wr_uart,
  output logic [DATA_LENGTH-1:0] transmit_data,
  output logic [ADDR_WIDTH-1:0]  reg_addr,
  output logic [DATA_LENGTH-1:0] reg_wdata,
  output logic                   reg_we,
  output logic                   reg_re,
  input  logic [DATA_LENGTH-1:0] reg_rdata,
  output logic                   frame_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DATA_LENGTH-1:0] CMD_WR   = DATA_LENGTH'(8'h57);
  localparam logic [DATA_LENGTH-1:0] CMD_RD   = DATA_LENGTH'(8'h52);
  localparam logic [DATA_LENGTH-1:0] RESP_ACK = DATA_LENGTH'(8'h06);
  localparam logic [DATA_LENGTH-1:0] RESP_NAK = DATA_LENGTH'(8'h15);
  localparam logic [CNT_W-1:0]       TMO_MAX  = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    BUS_WR,
    BUS_RD,
    RD_WAIT,
    SEND
  } state_t;

  state_t                 state_q;
  logic                   is_write_q;
  logic [CNT_W-1:0]       tmo_q;
  logic [CNT_W-1:0]       tmo_d;
  logic                   tmo_hit_c;
  logic [ADDR_WIDTH-1:0]  reg_addr_q;
  logic [DATA_LENGTH-1:0] reg_wdata_q;
  logic                   reg_we_q;
  logic                   reg_re_q;
  logic [DATA_LENGTH-1:0] resp_q;
  logic                   frame_error_q;
  logic                   pop_c;

  // Pop whenever a byte-consuming state sees data; SEND only pushes once TX has room.
  assign pop_c   = ((state_q == IDLE) || (state_q == GET_ADDR) || (state_q == GET_DATA))
                   && !rx_empty;
  assign rd_uart = pop_c;
  assign wr_uart = (state_q == SEND) && !tx_full;

  // Counter value after this idle cycle; timing out once it would reach the limit.
  assign tmo_d     = tmo_q + CNT_W'(1);
  assign tmo_hit_c = (tmo_d == TMO_MAX);

  assign transmit_data = resp_q;
  assign reg_addr      = reg_addr_q;
  assign reg_wdata     = reg_wdata_q;
  assign reg_we        = reg_we_q;
  assign reg_re        = reg_re_q;
  assign frame_error   = frame_error_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      is_write_q    <= 1'b0;
      tmo_q         <= '0;
      reg_addr_q    <= '0;
      reg_wdata_q   <= '0;
      reg_we_q      <= 1'b0;
      reg_re_q      <= 1'b0;
      resp_q        <= '0;
      frame_error_q <= 1'b0;
    end else begin
      reg_we_q      <= 1'b0;
      reg_re_q      <= 1'b0;
      frame_error_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (!rx_empty) begin
            if ((receive_data == CMD_WR) || (receive_data == CMD_RD)) begin
              is_write_q <= (receive_data == CMD_WR);
              state_q    <= GET_ADDR;
            end else begin
              resp_q        <= RESP_NAK;
              frame_error_q <= 1'b1;
              state_q       <= SEND;
            end
          end
        end
        GET_ADDR: begin
          if (!rx_empty) begin
            reg_addr_q <= ADDR_WIDTH'(receive_data);
            tmo_q      <= '0;
            reg_re_q   <= !is_write_q;
            state_q    <= is_write_q ? GET_DATA : BUS_RD;
          end else if (tmo_hit_c) begin
            tmo_q         <= '0;
            frame_error_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        GET_DATA: begin
          if (!rx_empty) begin
            reg_wdata_q <= receive_data;
            tmo_q       <= '0;
            reg_we_q    <= 1'b1;
            state_q     <= BUS_WR;
          end else if (tmo_hit_c) begin
            tmo_q         <= '0;
            frame_error_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        BUS_WR: begin
          resp_q  <= RESP_ACK;
          state_q <= SEND;
        end
        BUS_RD: begin
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          resp_q  <= reg_rdata;
          state_q <= SEND;
        end
        SEND: begin
          if (!tx_full) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
